// File: rtl/cache_line_ctrl_pkg.sv
// Shared definitions for the cache line miss/refill path.
// The tag store uses the same default widths and address packing.
package cache_pkg;

    localparam int DEF_LINE_WORDS   = 8;
    localparam int DEF_WORDSEL_WID  = $clog2(DEF_LINE_WORDS);
    localparam int DEF_ENTRYSEL_WID = 4;
    localparam int DEF_TAG_WID      = 14;
    localparam int DEF_DATA_WID     = 32;
    localparam int DEF_ADDR_WID     = DEF_TAG_WID + DEF_ENTRYSEL_WID + DEF_WORDSEL_WID + 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WBACK  = 2'd1,
        ST_FILL   = 2'd2,
        ST_COMMIT = 2'd3
    } line_state_t;

    // Word-aligned byte address of one word inside a cache line.
    function automatic logic [DEF_ADDR_WID-1:0] pack_addr(
        input logic [DEF_TAG_WID-1:0]      tag,
        input logic [DEF_ENTRYSEL_WID-1:0] ent,
        input logic [DEF_WORDSEL_WID-1:0]  word
    );
        return {tag, ent, word, 2'b00};
    endfunction

endpackage

// File: rtl/cache_line_ctrl_if.sv
// BIU and cache data RAM signals seen by the line controller.
// master = line controller, slave = BIU/RAM side.
interface cache_line_ctrl_if
    import cache_pkg::*;
#(
    parameter int DATA_WID  = DEF_DATA_WID,
    parameter int ADDR_WID  = DEF_ADDR_WID,
    parameter int MADDR_WID = DEF_ENTRYSEL_WID + DEF_WORDSEL_WID
);

    logic                 biu_req;
    logic                 biu_we;
    logic [ADDR_WID-1:0]  biu_addr;
    logic [DATA_WID-1:0]  biu_wdata;
    logic                 biu_ack;
    logic [DATA_WID-1:0]  biu_rdata;

    logic [MADDR_WID-1:0] mem_addr;
    logic                 mem_we;
    logic [DATA_WID-1:0]  mem_wdata;
    logic [DATA_WID-1:0]  mem_rdata;

    modport master (
        output biu_req, biu_we, biu_addr, biu_wdata, mem_addr, mem_we, mem_wdata,
        input  biu_ack, biu_rdata, mem_rdata
    );

    modport slave (
        input  biu_req, biu_we, biu_addr, biu_wdata, mem_addr, mem_we, mem_wdata,
        output biu_ack, biu_rdata, mem_rdata
    );

endinterface

// File: rtl/cache_line_ctrl_word_cnt.sv
// Word index within the line being written back or refilled.
// Line length is a power of two, so the last word is all ones and the count wraps to 0.
module line_word_cnt #(
    parameter int WID = 3
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           i_clear,
    input  logic           i_inc,
    output logic [WID-1:0] o_cnt,
    output logic           o_last
);

    logic [WID-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_cnt <= '0;
        end else if (i_inc) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_cnt  = r_cnt;
    assign o_last = &r_cnt;

endmodule

// File: rtl/cache_line_ctrl.sv
// Miss/refill sequencer: stalls the core, optionally writes back a dirty victim,
// refills the line word by word from the BIU and commits the new tag.
module cache_line_ctrl
    import cache_pkg::*;
#(
    parameter int   LINE_WORDS   = DEF_LINE_WORDS,
    parameter int   WORDSEL_WID  = $clog2(LINE_WORDS),
    parameter int   ENTRYSEL_WID = DEF_ENTRYSEL_WID,
    parameter int   TAG_WID      = DEF_TAG_WID,
    parameter int   DATA_WID     = DEF_DATA_WID,
    parameter int   ADDR_WID     = TAG_WID + ENTRYSEL_WID + WORDSEL_WID + 2,
    parameter logic WBACK_ENABLE = 1'b0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_line_miss,
    input  logic                    i_replace_dirty,
    input  logic [TAG_WID-1:0]      i_address_tag,
    input  logic [ENTRYSEL_WID-1:0] i_address_ent,
    input  logic [TAG_WID-1:0]      i_victim_tag,
    output logic                    o_core_stall,
    output logic                    o_line_refill,
    output logic [TAG_WID-1:0]      o_refill_tag,
    output logic                    o_writeback_ok,
    cache_line_ctrl_if.master       bus_if
);

    line_state_t                         r_state;
    line_state_t                         w_nextState;
    logic [TAG_WID-1:0]                  r_tag;
    logic [ENTRYSEL_WID-1:0]             r_ent;
    logic [TAG_WID-1:0]                  r_vtag;
    logic                                r_wbOk;

    logic                                w_cntClear;
    logic                                w_cntInc;
    logic [WORDSEL_WID-1:0]              w_cnt;
    logic                                w_cntLast;
    logic                                w_lastAck;

    logic                                w_biuReq;
    logic                                w_biuWe;
    logic [ADDR_WID-1:0]                 w_biuAddr;
    logic [ENTRYSEL_WID+WORDSEL_WID-1:0] w_memAddr;
    logic                                w_memWe;
    logic [DATA_WID-1:0]                 w_memRdata;
    logic [DATA_WID-1:0]                 w_biuRdata;

    line_word_cnt #(
        .WID (WORDSEL_WID)
    ) u_wordCnt (
        .clk     (clk),
        .rst     (rst),
        .i_clear (w_cntClear),
        .i_inc   (w_cntInc),
        .o_cnt   (w_cnt),
        .o_last  (w_cntLast)
    );

    assign w_lastAck = bus_if.biu_ack && w_cntLast;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_tag   <= '0;
            r_ent   <= '0;
            r_vtag  <= '0;
            r_wbOk  <= 1'b0;
        end else begin
            r_state <= w_nextState;
            r_wbOk  <= WBACK_ENABLE && (r_state == ST_WBACK) && w_lastAck;
            if ((r_state == ST_IDLE) && i_line_miss) begin
                r_tag  <= i_address_tag;
                r_ent  <= i_address_ent;
                r_vtag <= i_victim_tag;
            end
        end
    end

    // Acks are only honoured while a transfer is in flight; the count restarts
    // for each line and again between write-back and refill.
    always_comb begin
        w_nextState   = r_state;
        w_cntClear    = 1'b0;
        w_cntInc      = 1'b0;
        w_biuReq      = 1'b0;
        w_biuWe       = 1'b0;
        w_biuAddr     = '0;
        w_memAddr     = '0;
        w_memWe       = 1'b0;
        o_line_refill = 1'b0;
        o_refill_tag  = '0;
        case (r_state)
            ST_IDLE: begin
                w_cntClear = 1'b1;
                if (i_line_miss) begin
                    w_nextState = (WBACK_ENABLE && i_replace_dirty) ? ST_WBACK : ST_FILL;
                end
            end
            ST_WBACK: begin
                w_biuReq   = 1'b1;
                w_biuWe    = 1'b1;
                w_biuAddr  = {r_vtag, r_ent, w_cnt, 2'b00};
                w_memAddr  = {r_ent, w_cnt};
                w_cntInc   = bus_if.biu_ack;
                if (w_lastAck) begin
                    w_cntClear  = 1'b1;
                    w_nextState = ST_FILL;
                end
            end
            ST_FILL: begin
                w_biuReq   = 1'b1;
                w_biuAddr  = {r_tag, r_ent, w_cnt, 2'b00};
                w_memAddr  = {r_ent, w_cnt};
                w_memWe    = bus_if.biu_ack;
                w_cntInc   = bus_if.biu_ack;
                if (w_lastAck) begin
                    w_nextState = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                o_line_refill = 1'b1;
                o_refill_tag  = r_tag;
                w_memAddr     = {r_ent, w_cnt};
                w_nextState   = ST_IDLE;
            end
            default: begin
                w_nextState = ST_IDLE;
            end
        endcase
    end

    assign w_memRdata       = bus_if.mem_rdata;
    assign w_biuRdata       = bus_if.biu_rdata;

    assign o_core_stall     = i_line_miss || (r_state != ST_IDLE);
    assign o_writeback_ok   = r_wbOk;

    assign bus_if.biu_req   = w_biuReq;
    assign bus_if.biu_we    = w_biuWe;
    assign bus_if.biu_addr  = w_biuAddr;
    assign bus_if.biu_wdata = w_memRdata;
    assign bus_if.mem_addr  = w_memAddr;
    assign bus_if.mem_we    = w_memWe;
    assign bus_if.mem_wdata = w_biuRdata;

endmodule

// File: tb/tb_cache_line_ctrl.sv
// Directed bench for cache_line_ctrl: dut 0 has write-back disabled, dut 1 enabled.
// BIU read data and cache RAM read data are fixed functions of the presented address.
module tb_cache_line_ctrl;
    import cache_pkg::*;

    logic        clk;
    logic        rst;
    logic        lineMiss[2];
    logic        replaceDirty[2];
    logic [13:0] addrTag[2];
    logic [3:0]  addrEnt[2];
    logic [13:0] victimTag[2];
    logic        biuAck[2];

    logic        coreStall[2];
    logic        lineRefill[2];
    logic [13:0] refillTag[2];
    logic        wbOk[2];
    logic        biuReq[2];
    logic        biuWe[2];
    logic [22:0] biuAddr[2];
    logic [31:0] biuWdata[2];
    logic [6:0]  memAddr[2];
    logic        memWe[2];
    logic [31:0] memWdata[2];

    logic [31:0] ram[2][128];
    int          wbPulse[2];
    int          refillPulse[2];
    int          missCyc[2];
    int          cyc = 0;
    int          vecCount = 0;
    int          missCount = 0;

    cache_line_ctrl_if bus0 ();
    cache_line_ctrl_if bus1 ();

    cache_line_ctrl #(.WBACK_ENABLE(1'b0)) dut0 (
        .clk             (clk),
        .rst             (rst),
        .i_line_miss     (lineMiss[0]),
        .i_replace_dirty (replaceDirty[0]),
        .i_address_tag   (addrTag[0]),
        .i_address_ent   (addrEnt[0]),
        .i_victim_tag    (victimTag[0]),
        .o_core_stall    (coreStall[0]),
        .o_line_refill   (lineRefill[0]),
        .o_refill_tag    (refillTag[0]),
        .o_writeback_ok  (wbOk[0]),
        .bus_if          (bus0)
    );

    cache_line_ctrl #(.WBACK_ENABLE(1'b1)) dut1 (
        .clk             (clk),
        .rst             (rst),
        .i_line_miss     (lineMiss[1]),
        .i_replace_dirty (replaceDirty[1]),
        .i_address_tag   (addrTag[1]),
        .i_address_ent   (addrEnt[1]),
        .i_victim_tag    (victimTag[1]),
        .o_core_stall    (coreStall[1]),
        .o_line_refill   (lineRefill[1]),
        .o_refill_tag    (refillTag[1]),
        .o_writeback_ok  (wbOk[1]),
        .bus_if          (bus1)
    );

    assign bus0.biu_ack   = biuAck[0];
    assign bus1.biu_ack   = biuAck[1];
    assign bus0.biu_rdata = 32'hD000_0000 | 32'(bus0.biu_addr);
    assign bus1.biu_rdata = 32'hD000_0000 | 32'(bus1.biu_addr);
    assign bus0.mem_rdata = 32'hC000_0000 | 32'(bus0.mem_addr);
    assign bus1.mem_rdata = 32'hC000_0000 | 32'(bus1.mem_addr);

    assign biuReq[0]   = bus0.biu_req;
    assign biuReq[1]   = bus1.biu_req;
    assign biuWe[0]    = bus0.biu_we;
    assign biuWe[1]    = bus1.biu_we;
    assign biuAddr[0]  = bus0.biu_addr;
    assign biuAddr[1]  = bus1.biu_addr;
    assign biuWdata[0] = bus0.biu_wdata;
    assign biuWdata[1] = bus1.biu_wdata;
    assign memAddr[0]  = bus0.mem_addr;
    assign memAddr[1]  = bus1.mem_addr;
    assign memWe[0]    = bus0.mem_we;
    assign memWe[1]    = bus1.mem_we;
    assign memWdata[0] = bus0.mem_wdata;
    assign memWdata[1] = bus1.mem_wdata;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Cache data RAM models, written by the refill strobe.
    always @(posedge clk) if (memWe[0]) ram[0][memAddr[0]] <= memWdata[0];
    always @(posedge clk) if (memWe[1]) ram[1][memAddr[1]] <= memWdata[1];

    // Pulse counters for the two registered strobes.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (wbOk[d])       wbPulse[d]     = wbPulse[d] + 1;
            if (lineRefill[d]) refillPulse[d] = refillPulse[d] + 1;
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        vecCount++;
        if (observed !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", tag, observed, expected, cyc);
        end
    endtask

    task automatic applyStimulus(input int d, input logic miss, input logic dirty,
                                 input logic [13:0] tag, input logic [3:0] ent, input logic [13:0] vtag);
        lineMiss[d]     = miss;
        replaceDirty[d] = dirty;
        addrTag[d]      = tag;
        addrEnt[d]      = ent;
        victimTag[d]    = vtag;
    endtask

    // Presents a miss for one cycle, then scrambles the request inputs.
    task automatic startMiss(input int d, input logic [13:0] tag, input logic [3:0] ent,
                             input logic [13:0] vtag, input logic dirty);
        @(negedge clk);
        applyStimulus(d, 1'b1, dirty, tag, ent, vtag);
        #1;
        checkOutput("miss_stall", coreStall[d], 1'b1);
        checkOutput("miss_idle_req", biuReq[d], 1'b0);
        @(posedge clk);
        #1;
        applyStimulus(d, 1'b0, 1'b0, ~tag, ~ent, ~vtag);
        missCyc[d] = cyc;
    endtask

    // One word transfer with a number of wait cycles before its ack.
    task automatic runWord(input int d, input logic isWrite, input logic [13:0] tag,
                           input logic [3:0] ent, input int w, input int waits);
        logic [2:0]  wb;
        logic [22:0] expAddr;
        wb      = w[2:0];
        expAddr = {tag, ent, wb, 2'b00};
        repeat (waits) begin
            @(negedge clk);
            biuAck[d] = 1'b0;
            #1;
            checkOutput("wait_stall", coreStall[d], 1'b1);
            checkOutput("wait_mem_we", memWe[d], 1'b0);
            checkOutput("wait_addr", biuAddr[d], expAddr);
        end
        @(negedge clk);
        biuAck[d] = 1'b1;
        #1;
        checkOutput("biu_req", biuReq[d], 1'b1);
        checkOutput("biu_we", biuWe[d], isWrite);
        checkOutput("biu_addr", biuAddr[d], expAddr);
        checkOutput("mem_addr", memAddr[d], {ent, wb});
        checkOutput("mem_we", memWe[d], !isWrite);
        if (isWrite) checkOutput("biu_wdata", biuWdata[d], 32'hC000_0000 | 32'({ent, wb}));
    endtask

    // Commit cycle then return to idle; expLat counts edges from the miss edge.
    task automatic finishLine(input int d, input logic [13:0] tag, input logic [3:0] ent, input int expLat);
        @(negedge clk);
        biuAck[d] = 1'b0;
        #1;
        checkOutput("refill", lineRefill[d], 1'b1);
        checkOutput("refill_tag", refillTag[d], tag);
        checkOutput("commit_mem_addr", memAddr[d], {ent, 3'd0});
        checkOutput("commit_req", biuReq[d], 1'b0);
        checkOutput("commit_stall", coreStall[d], 1'b1);
        checkOutput("commit_latency", cyc - missCyc[d], expLat);
        @(negedge clk);
        #1;
        checkOutput("refill_done", lineRefill[d], 1'b0);
        checkOutput("stall_release", coreStall[d], 1'b0);
        checkOutput("release_latency", cyc - missCyc[d], expLat + 1);
    endtask

    task automatic checkLine(input int d, input logic [13:0] tag, input logic [3:0] ent);
        logic [2:0] wb;
        for (int w = 0; w < 8; w++) begin
            wb = w[2:0];
            checkOutput("line_data", ram[d][{ent, wb}], 32'hD000_0000 | 32'({tag, ent, wb, 2'b00}));
        end
    endtask

    initial begin
        int snap;
        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            applyStimulus(d, 1'b0, 1'b0, 14'h0, 4'h0, 14'h0);
            biuAck[d]      = 1'b0;
            wbPulse[d]     = 0;
            refillPulse[d] = 0;
        end
        repeat (2) @(negedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            checkOutput("rst_stall", coreStall[d], 1'b0);
            checkOutput("rst_refill", lineRefill[d], 1'b0);
            checkOutput("rst_refill_tag", refillTag[d], 14'h0);
            checkOutput("rst_wb_ok", wbOk[d], 1'b0);
            checkOutput("rst_biu_req", biuReq[d], 1'b0);
            checkOutput("rst_biu_we", biuWe[d], 1'b0);
            checkOutput("rst_biu_addr", biuAddr[d], 23'h0);
            checkOutput("rst_mem_addr", memAddr[d], 7'h0);
            checkOutput("rst_mem_we", memWe[d], 1'b0);
        end
        lineMiss[0] = 1'b1;
        #1;
        checkOutput("rst_stall_comb", coreStall[0], 1'b1);
        lineMiss[0] = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        $display("[TB] clean miss, zero-wait BIU");
        startMiss(0, 14'h0A5, 4'h3, 14'h000, 1'b0);
        for (int w = 0; w < 8; w++) runWord(0, 1'b0, 14'h0A5, 4'h3, w, 0);
        finishLine(0, 14'h0A5, 4'h3, 8);
        checkLine(0, 14'h0A5, 4'h3);

        $display("[TB] dirty victim write-back");
        snap = wbPulse[1];
        startMiss(1, 14'h0B7, 4'h5, 14'h011, 1'b1);
        for (int w = 0; w < 8; w++) runWord(1, 1'b1, 14'h011, 4'h5, w, 0);
        @(negedge clk);
        biuAck[1] = 1'b0;
        #1;
        checkOutput("wb_ok_pulse", wbOk[1], 1'b1);
        checkOutput("wb_to_fill_we", biuWe[1], 1'b0);
        checkOutput("wb_to_fill_addr", biuAddr[1], {14'h0B7, 4'h5, 3'd0, 2'b00});
        for (int w = 0; w < 8; w++) runWord(1, 1'b0, 14'h0B7, 4'h5, w, 0);
        finishLine(1, 14'h0B7, 4'h5, 17);
        checkOutput("wb_ok_count", wbPulse[1] - snap, 1);
        checkLine(1, 14'h0B7, 4'h5);

        $display("[TB] wait states");
        startMiss(1, 14'h3C1, 4'hF, 14'h2AA, 1'b0);
        for (int w = 0; w < 8; w++) runWord(1, 1'b0, 14'h3C1, 4'hF, w, 2);
        finishLine(1, 14'h3C1, 4'hF, 24);
        checkLine(1, 14'h3C1, 4'hF);

        $display("[TB] reset during fill");
        snap = refillPulse[0];
        startMiss(0, 14'h1F0, 4'h7, 14'h000, 1'b0);
        for (int w = 0; w < 4; w++) runWord(0, 1'b0, 14'h1F0, 4'h7, w, 0);
        @(negedge clk);
        biuAck[0] = 1'b0;
        rst       = 1'b1;
        #1;
        checkOutput("pre_rst_addr", biuAddr[0], {14'h1F0, 4'h7, 3'd4, 2'b00});
        @(negedge clk);
        #1;
        checkOutput("post_rst_req", biuReq[0], 1'b0);
        checkOutput("post_rst_stall", coreStall[0], 1'b0);
        checkOutput("post_rst_refill", lineRefill[0], 1'b0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("no_partial_commit", refillPulse[0] - snap, 0);
        startMiss(0, 14'h2F0, 4'h7, 14'h000, 1'b0);
        for (int w = 0; w < 8; w++) runWord(0, 1'b0, 14'h2F0, 4'h7, w, 0);
        finishLine(0, 14'h2F0, 4'h7, 8);
        checkLine(0, 14'h2F0, 4'h7);

        $display("[TB] spurious ack and miss");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            biuAck[0] = 1'b1;
            #1;
            checkOutput("idle_ack_req", biuReq[0], 1'b0);
            checkOutput("idle_ack_mem_we", memWe[0], 1'b0);
        end
        startMiss(0, 14'h0C3, 4'h2, 14'h000, 1'b0);
        for (int w = 0; w < 8; w++) begin
            lineMiss[0] = w[0];
            addrTag[0]  = 14'h2BAD;
            addrEnt[0]  = 4'hD;
            runWord(0, 1'b0, 14'h0C3, 4'h2, w, 0);
        end
        lineMiss[0] = 1'b0;
        finishLine(0, 14'h0C3, 4'h2, 8);
        checkLine(0, 14'h0C3, 4'h2);

        $display("[TB] dirty victim with write-back disabled");
        snap = wbPulse[0];
        startMiss(0, 14'h155, 4'hA, 14'h022, 1'b1);
        for (int w = 0; w < 8; w++) runWord(0, 1'b0, 14'h155, 4'hA, w, 0);
        finishLine(0, 14'h155, 4'hA, 8);
        checkOutput("no_wb_ok", wbPulse[0] - snap, 0);
        checkLine(0, 14'h155, 4'hA);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule

// File: doc/cache_line_ctrl.md
# cache_line_ctrl

Miss/refill sequencer for the direct-mapped cache tag store. It watches the tag store's `line_miss`/`replace_dirty` outputs and stalls the core. When write-back is enabled and the victim line is dirty, it writes the victim back over the BIU, then refills the line word by word into cache data memory. It closes the transaction by pulsing `line_refill` with the captured tag. It sits between the tag store, the cache data RAM and the BIU.

## Interface
- `LINE_WORDS`, 8: words per cache line; power of two, ≥2.
- `WORDSEL_WID`, `$clog2(LINE_WORDS)`: word index width.
- `ENTRYSEL_WID`, 4: entry index width; matches the tag store.
- `TAG_WID`, 14: tag width; matches the tag store.
- `DATA_WID`, 32: BIU/cache word width.
- `ADDR_WID`, `TAG_WID+ENTRYSEL_WID+WORDSEL_WID+2`: byte address width.
- `WBACK_ENABLE`, 1'b0: enables the write-back path.

Ports:
- `clk` in 1: clock.
- `rst` in 1: synchronous, active-high reset.
- `line_miss` in 1: miss from the tag store.
- `replace_dirty` in 1: victim is dirty.
- `address_tag` in TAG_WID: tag of the missing access.
- `address_ent` in ENTRYSEL_WID: entry of the missing access.
- `victim_tag` in TAG_WID: tag currently stored at `address_ent`.
- `core_stall` out 1: hold the core's access.
- `line_refill` out 1: 1-cycle refill commit to the tag store.
- `refill_tag` out TAG_WID: tag to install.
- `writeback_ok` out 1: 1-cycle victim-clean pulse to the tag store.
- `biu_req` out 1: BIU word request.
- `biu_we` out 1: 1 = write, 0 = read.
- `biu_addr` out ADDR_WID: word-aligned byte address.
- `biu_wdata` out DATA_WID: write data (equals `mem_rdata`).
- `biu_ack` in 1: word done; read data valid the same cycle.
- `biu_rdata` in DATA_WID: read data.
- `mem_addr` out ENTRYSEL_WID+WORDSEL_WID: cache RAM word address, `{entry, word}`.
- `mem_we` out 1: cache RAM write strobe.
- `mem_wdata` out DATA_WID: equals `biu_rdata`.
- `mem_rdata` in DATA_WID: cache RAM read data, combinational.

## Operation
States: IDLE, WBACK, FILL, COMMIT.
- **IDLE**
  - On `line_miss`, capture `address_tag`→`tag_q`, `address_ent`→`ent_q`, `victim_tag`→`vtag_q`.
  - Clear `cnt`.
  - Go to WBACK if `WBACK_ENABLE & replace_dirty`, else FILL.
- **WBACK**
  - Outputs: `biu_req=1`, `biu_we=1`, `biu_addr={vtag_q,ent_q,cnt,2'b00}`, `mem_addr={ent_q,cnt}`.
  - `biu_wdata=mem_rdata`.
  - On `biu_ack`, `cnt++`.
  - On the ack with `cnt==LINE_WORDS-1`: pulse `writeback_ok` the next cycle, clear `cnt`, go to FILL.
- **FILL**
  - Outputs: `biu_req=1`, `biu_we=0`, `biu_addr={tag_q,ent_q,cnt,2'b00}`, `mem_addr={ent_q,cnt}`.
  - `mem_we=biu_ack`.
  - On `biu_ack`, `cnt++`.
  - On the last ack, go to COMMIT.
- **COMMIT**
  - `line_refill=1`, `refill_tag=tag_q`, `mem_addr={ent_q,cnt}`.
  - Next state is IDLE.
- **Stall**
  - `core_stall = line_miss | (state != IDLE)`.
  - The core re-presents the access after COMMIT; the tag store then hits.
- **Width rules**
  - `cnt` is WORDSEL_WID bits and wraps to 0 naturally after the last word.
  - `biu_addr` is a pure concatenation; no arithmetic.
- **Boundary conditions**
  - `biu_ack` outside WBACK/FILL is ignored.
  - `line_miss` outside IDLE is ignored; captured values are held.
  - `WBACK_ENABLE=0`: WBACK is unreachable and `writeback_ok` is constant 0.
  - `rst` mid-operation returns to IDLE immediately. A partially filled line is never committed, so it stays invalid.
  - The BIU must drop any in-flight transfer when `biu_req` falls.

## Timing
- **Reset values:** state IDLE, `cnt=0`, `tag_q`/`ent_q`/`vtag_q=0`. All outputs are 0 except combinational `core_stall=line_miss`.
- **Registered vs. combinational outputs**
  - `writeback_ok` and `line_refill` are registered-state decodes, each exactly 1 cycle wide.
  - `biu_*` and `mem_*` are combinational from state, `cnt` and captured values.
- **BIU handshake:** `biu_req` stays high until the ack of the last word. The BIU may ack on consecutive cycles, with 0 or more wait cycles between acks.
- **Latency:** miss to `line_refill` is 1 + N_fill_cycles + 1 (COMMIT). Write-back adds N_wb_cycles + 0; `writeback_ok` coincides with the first FILL cycle.
- **Minimum clean miss, LINE_WORDS=8, zero-wait BIU:** 10 cycles from miss to `core_stall` low.

## Structure
- **Shared package `cache_pkg`:**
  - state enum (IDLE/WBACK/FILL/COMMIT);
  - default widths (TAG_WID, ENTRYSEL_WID, LINE_WORDS);
  - an address-pack function `{tag, ent, word, 2'b00}`, also used by the tag store.
- **Sub-module `line_word_cnt`:** word counter with clear/inc/last. One FSM plus this counter; no other hierarchy.

## Test plan
1. **Clean miss, zero-wait BIU** (WBACK_ENABLE=0, tag 0x0A5, ent 3, LINE_WORDS=8, ack every cycle):
   - 8 reads at 0x…A5_3_0..7;
   - `mem_we` asserted 8 times at `mem_addr` 0x18..0x1F;
   - `line_refill`=1 with `refill_tag`=0x0A5 on cycle 10.
2. **Dirty victim** (WBACK_ENABLE=1, `victim_tag` 0x011):
   - 8 writes at `{0x011, ent, 0..7}` carrying `mem_rdata`;
   - `writeback_ok` pulses once;
   - then 8 reads, then `line_refill`.
3. **Wait states** (ack every 3rd cycle): `cnt` advances only on ack; the line is filled correctly; `core_stall` stays high throughout.
4. **Reset at word 4 of FILL:**
   - next cycle state is IDLE, `biu_req`=0, `line_refill` never asserted;
   - a new miss restarts at word 0.
5. **Spurious inputs:** `biu_ack` in IDLE and `line_miss` toggling during FILL have no effect on `cnt` or captured `tag_q`/`ent_q`.
6. **`replace_dirty` with WBACK_ENABLE=0:** goes straight to FILL; `writeback_ok` and `biu_we` stay 0.
